// File: rtl/beep_if.sv
// Control/status bundle between the register block and the beep timer.
// Master drives terminal count and mode/enable; slave returns count and expiry flag.
interface beep_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] timetogo;
   logic             countMode;
   logic             countAct;
   logic [WIDTH-1:0] countVal;
   logic             fullflag;

   modport master (
      output timetogo,
      output countMode,
      output countAct,
      input  countVal,
      input  fullflag
   );

   modport slave (
      input  timetogo,
      input  countMode,
      input  countAct,
      output countVal,
      output fullflag
   );
endinterface

// File: rtl/beep.sv
// Programmable cycle timer: loop or single-shot, one-cycle fullflag per expiry.
// Optional BEEP_OUT_EN adds a beep_out square wave toggled on each expiry.
module beep #(
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
`ifdef BEEP_OUT_EN
   output logic beep_out,
`endif
   beep_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN_LOOP = 2'd1,
      RUN_ONCE = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e           state_q;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] tgt_q;
   logic             flag_q;
   logic             act_q;
`ifdef BEEP_OUT_EN
   logic             beep_q;
`endif

   logic term;
   logic start;

   // target is never 0 while running, so target-1 cannot wrap
   assign term  = (cnt_q == (tgt_q - ONE));
   assign start = (bus.timetogo != '0) && bus.countAct &&
                  (bus.countMode || !act_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tgt_q   <= '0;
         flag_q  <= 1'b0;
         act_q   <= 1'b0;
`ifdef BEEP_OUT_EN
         beep_q  <= 1'b0;
`endif
      end else begin
         act_q <= bus.countAct;
         unique case (state_q)
            IDLE: begin
               cnt_q  <= '0;
               flag_q <= 1'b0;
`ifdef BEEP_OUT_EN
               beep_q <= 1'b0;
`endif
               if (start) begin
                  tgt_q   <= bus.timetogo;
                  state_q <= bus.countMode ? RUN_LOOP : RUN_ONCE;
               end
            end
            RUN_LOOP: begin
               // abort takes priority over a coincident expiry
               if (!bus.countAct) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  flag_q  <= 1'b0;
`ifdef BEEP_OUT_EN
                  beep_q  <= 1'b0;
`endif
               end else if (term) begin
                  cnt_q  <= '0;
                  flag_q <= 1'b1;
`ifdef BEEP_OUT_EN
                  beep_q <= ~beep_q;
`endif
               end else begin
                  cnt_q  <= cnt_q + ONE;
                  flag_q <= 1'b0;
               end
            end
            RUN_ONCE: begin
               if (term) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  flag_q  <= 1'b1;
`ifdef BEEP_OUT_EN
                  beep_q  <= ~beep_q;
`endif
               end else begin
                  cnt_q  <= cnt_q + ONE;
                  flag_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               flag_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.countVal = cnt_q;
   assign bus.fullflag = flag_q;
`ifdef BEEP_OUT_EN
   assign beep_out     = beep_q;
`endif

endmodule

// File: tb/tb_beep.sv
// Bench for beep: table of runs with pulse counts, corner sequences,
// random stimulus, all checked every cycle against an elapsed-time model.
module tb_beep;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   beep_if #(.WIDTH(W)) bus ();
`ifdef BEEP_OUT_EN
   logic beep_out;
`endif

   beep #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef BEEP_OUT_EN
      .beep_out (beep_out),
`endif
      .bus      (bus)
   );

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   // model: running flag, period and edges elapsed since start
   bit m_run  = 0;
   bit m_loop = 0;
   bit m_prev = 0;
   int m_T    = 0;
   int m_p    = 0;
   int exp_cnt  = 0;
   bit exp_flag = 0;

   typedef struct {
      int ttg;
      bit mode;
      int cycles;
      int exp_pulses;
   } vec_t;
   vec_t tbl[9];

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_run    = 0;
      m_prev   = 0;
      exp_cnt  = 0;
      exp_flag = 0;
   endtask

   task automatic model_edge();
      if (!rst) begin
         model_reset();
      end else begin
         if (!m_run) begin
            exp_cnt  = 0;
            exp_flag = 0;
            if (bus.timetogo != 0 && bus.countAct &&
                (bus.countMode || !m_prev)) begin
               m_run  = 1;
               m_loop = bus.countMode;
               m_T    = int'(bus.timetogo);
               m_p    = 0;
            end
         end else if (m_loop && !bus.countAct) begin
            m_run    = 0;
            exp_cnt  = 0;
            exp_flag = 0;
         end else begin
            m_p++;
            exp_cnt  = m_p % m_T;
            exp_flag = (exp_cnt == 0);
            if (!m_loop && m_p == m_T) m_run = 0;
         end
         m_prev = bus.countAct;
      end
   endtask

   task automatic step(string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk({tag, ".countVal"}, longint'(bus.countVal), longint'(exp_cnt));
      chk({tag, ".fullflag"}, longint'(bus.fullflag), longint'(exp_flag));
      if (bus.fullflag) pulses++;
   endtask

   initial begin
      tbl[0] = '{ttg: 1000, mode: 1, cycles: 12000, exp_pulses: 12};
      tbl[1] = '{ttg: 600,  mode: 1, cycles: 12000, exp_pulses: 20};
      tbl[2] = '{ttg: 1000, mode: 0, cycles: 1005,  exp_pulses: 1};
      tbl[3] = '{ttg: 600,  mode: 0, cycles: 605,   exp_pulses: 1};
      tbl[4] = '{ttg: 0,    mode: 1, cycles: 50,    exp_pulses: 0};
      tbl[5] = '{ttg: 0,    mode: 0, cycles: 50,    exp_pulses: 0};
      tbl[6] = '{ttg: 1,    mode: 1, cycles: 40,    exp_pulses: 40};
      tbl[7] = '{ttg: 7,    mode: 1, cycles: 100,   exp_pulses: 14};
      tbl[8] = '{ttg: 1,    mode: 0, cycles: 10,    exp_pulses: 1};

      // reset held with live inputs
      rst           = 1'b0;
      bus.timetogo  = 1000;
      bus.countMode = 1'b1;
      bus.countAct  = 1'b1;
      repeat (200) step("reset");
      bus.countAct = 1'b0;
      rst = 1'b1;
      repeat (3) step("post_reset");

      // table runs
      for (int i = 0; i < 9; i++) begin
         bus.timetogo  = tbl[i].ttg;
         bus.countMode = tbl[i].mode;
         bus.countAct  = 1'b1;
         step($sformatf("tbl%0d.start", i));
         if (!tbl[i].mode) bus.countAct = 1'b0;
         pulses = 0;
         repeat (tbl[i].cycles) step($sformatf("tbl%0d.run", i));
         chk($sformatf("tbl%0d.pulses", i), pulses, tbl[i].exp_pulses);
         bus.countAct = 1'b0;
         repeat (3) step($sformatf("tbl%0d.idle", i));
      end

      // loop abort at countVal 500
      begin
         int guard = 0;
         bus.timetogo  = 1000;
         bus.countMode = 1'b1;
         bus.countAct  = 1'b1;
         step("abort.start");
         while (exp_cnt != 500 && guard < 2000) begin
            step("abort.run");
            guard++;
         end
         chk("abort.reach500", longint'(bus.countVal), 500);
         pulses = 0;
         bus.countAct = 1'b0;
         repeat (5) step("abort.drop");
         chk("abort.noflag", pulses, 0);
      end

      // re-trigger during a single run is ignored
      bus.timetogo  = 100;
      bus.countMode = 1'b0;
      bus.countAct  = 1'b1;
      step("retrig.start");
      bus.countAct = 1'b0;
      pulses = 0;
      repeat (30) step("retrig.run");
      bus.countAct = 1'b1;
      bus.timetogo = 5;
      step("retrig.pulse");
      bus.countAct = 1'b0;
      repeat (80) step("retrig.tail");
      chk("retrig.pulses", pulses, 1);

      // async reset mid-run clears at once
      bus.timetogo  = 50;
      bus.countMode = 1'b1;
      bus.countAct  = 1'b1;
      step("arst.start");
      repeat (20) step("arst.run");
      #2 rst = 1'b0;
      #1;
      chk("arst.countVal", longint'(bus.countVal), 0);
      chk("arst.fullflag", longint'(bus.fullflag), 0);
      model_reset();
      repeat (2) step("arst.hold");
      bus.countAct = 1'b0;
      rst = 1'b1;
      repeat (3) step("arst.release");

      // random stimulus, inputs also change mid-run
      repeat (4000) begin
         if ($urandom_range(0, 15) == 0) bus.timetogo = $urandom_range(0, 12);
         if ($urandom_range(0, 31) == 0) bus.countMode = 1'($urandom_range(0, 1));
         bus.countAct = ($urandom_range(0, 7) != 0);
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
